// File: rtl/sm4_keyexp_iter.sv
// sm4_keyexp_iter: iterative SM4 key-expansion engine. The 32 key-schedule rounds are
// folded onto ROUNDS_PER_CYCLE unrolled round units, so a key takes 32/ROUNDS_PER_CYCLE
// RUN cycles. Round keys are collected in a 32-word store and presented as one 1024-bit word.
// Ports:
//   CLK_i, RST_N_i           clock, asynchronous active-low reset
//   MK_i/MK_TAG_i/MK_DEC_i   master key (MK_i[127:96] = MK0), user tag, decrypt-order flag
//   MK_VALID_i/MK_READY_o    key-load handshake (ready only in IDLE)
//   KEY_CLR_i                synchronous zeroize/abort, highest priority
//   RK_o/RK_TAG_o            round keys (enc: RK_o[1023:992]=rk0; dec: reversed) and tag
//   RK_VALID_o/RK_READY_i    round-key handshake (valid only in DONE)
//   BUSY_o                   expansion in progress
module sm4_keyexp_iter #(
  parameter int unsigned ROUNDS_PER_CYCLE = 4,
  parameter int unsigned TAG_W            = 4
) (
  input  logic             CLK_i,
  input  logic             RST_N_i,
  input  logic [127:0]     MK_i,
  input  logic [TAG_W-1:0] MK_TAG_i,
  input  logic             MK_DEC_i,
  input  logic             MK_VALID_i,
  output logic             MK_READY_o,
  input  logic             KEY_CLR_i,
  output logic [1023:0]    RK_o,
  output logic [TAG_W-1:0] RK_TAG_o,
  output logic             RK_VALID_o,
  input  logic             RK_READY_i,
  output logic             BUSY_o
);

  localparam int unsigned R     = ROUNDS_PER_CYCLE;
  localparam int unsigned ITER  = 32 / R;
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  // S-box, entry 0 in the top byte
  localparam logic [2047:0] SBOX_FLAT = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  // CK constants, CK0 in the top word
  localparam logic [1023:0] CK_FLAT = {
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  generate
    if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16 || R == 32)) begin : g_bad_rpc
      $error("sm4_keyexp_iter: ROUNDS_PER_CYCLE must be 1,2,4,8,16 or 32");
    end
    if (TAG_W < 1) begin : g_bad_tag
      $error("sm4_keyexp_iter: TAG_W must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_FLAT[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
  endfunction

  // Key-schedule linear transform: b ^ (b <<< 13) ^ (b <<< 23)
  function automatic logic [31:0] lp(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  function automatic logic [31:0] ck_word(input logic [4:0] j);
    return CK_FLAT[(31 - int'(j)) * 32 +: 32];
  endfunction

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         k_q [4];
  logic [31:0]         rk_q [32];
  logic [TAG_W-1:0]    tag_q;
  logic                dec_q;
  logic                mk_ready_q;
  logic                busy_q;
  logic                rk_valid_q;

  logic [31:0]         k_d [4];
  logic [31:0]         rk_new [R];

  // R chained rounds starting at j = cnt*R; the K window slides by R words
  always_comb begin : p_rounds
    logic [31:0] w [R+4];
    logic [4:0]  base;
    base = 5'(int'(cnt_q) * int'(R));
    for (int i = 0; i < int'(R) + 4; i++) w[i] = '0;
    for (int r = 0; r < int'(R); r++) rk_new[r] = '0;
    for (int i = 0; i < 4; i++) begin
      w[i]   = k_q[i];
      k_d[i] = '0;
    end
    for (int r = 0; r < int'(R); r++) begin
      w[r+4] = w[r] ^ lp(tau(w[r+1] ^ w[r+2] ^ w[r+3] ^ ck_word(5'(int'(base) + r))));
      rk_new[r] = w[r+4];
    end
    for (int i = 0; i < 4; i++) k_d[i] = w[int'(R) + i];
  end

  // Control FSM, K window, round-key store and registered handshake outputs
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tag_q      <= '0;
      dec_q      <= 1'b0;
      mk_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++)  k_q[i]  <= '0;
      for (int s = 0; s < 32; s++) rk_q[s] <= '0;
    end else if (KEY_CLR_i) begin
      // zeroize wins over everything, including a handshake on this edge
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tag_q      <= '0;
      dec_q      <= 1'b0;
      mk_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++)  k_q[i]  <= '0;
      for (int s = 0; s < 32; s++) rk_q[s] <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (MK_VALID_i && mk_ready_q) begin
            k_q[0]     <= MK_i[127:96] ^ FK0;
            k_q[1]     <= MK_i[95:64]  ^ FK1;
            k_q[2]     <= MK_i[63:32]  ^ FK2;
            k_q[3]     <= MK_i[31:0]   ^ FK3;
            tag_q      <= MK_TAG_i;
            dec_q      <= MK_DEC_i;
            cnt_q      <= '0;
            state_q    <= ST_RUN;
            mk_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < 4; i++) k_q[i] <= k_d[i];
          // slots cnt*R .. cnt*R+R-1 are produced this cycle
          for (int s = 0; s < 32; s++) begin
            if (cnt_q == CNT_W'(s / int'(R))) rk_q[s] <= rk_new[s % int'(R)];
          end
          if (cnt_q == CNT_LAST) begin
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (RK_READY_i) begin
            state_q    <= ST_IDLE;
            rk_valid_q <= 1'b0;
            mk_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          mk_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          rk_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Output ordering from the latched decrypt flag
  always_comb begin
    RK_o = '0;
    for (int j = 0; j < 32; j++) begin
      RK_o[1023 - 32*j -: 32] = dec_q ? rk_q[31 - j] : rk_q[j];
    end
  end

  assign RK_TAG_o   = tag_q;
  assign MK_READY_o = mk_ready_q;
  assign BUSY_o     = busy_q;
  assign RK_VALID_o = rk_valid_q;

endmodule
